// File: rtl/uart_pkg.sv
// Shared UART types and helpers: transmitter FSM states, baud divisor, parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  // Clock cycles per line bit, integer-truncated.
  function automatic int unsigned baud_divisor(input int unsigned clock, input int unsigned baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth, pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned Depth  = 16,
  parameter int unsigned Width  = 8,
  parameter int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [Width-1:0]  wdata,
  input  logic              pop,
  output logic [Width-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [LevelW-1:0] level
);

  localparam int unsigned PtrW = $clog2(Depth);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: Depth must be a power of two and >= 2");
  end

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == LevelW'(Depth));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and count next-state; push+pop together leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered, parity and 1/2 stop bits latched per frame.
// Optional macro UART_TX_CTS_EN adds a synchronised active-low cts_n flow-control input.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned LEVEL_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
`ifdef UART_TX_CTS_EN
  input  logic                 cts_n,
`endif
  output logic                 uart_tx_pin,
  output logic                 tx_busy,
  output logic [LEVEL_W-1:0]   fifo_level
);

  localparam int unsigned BaudDiv = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam int unsigned BitW    = $clog2(DATA_BITS);

  if (BaudDiv < 2) begin : g_bad_div
    $error("uart_tx_cfg: baud divisor must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 cts_ok;

  sync_fifo #(
    .Depth  (FIFO_DEPTH),
    .Width  (DATA_BITS),
    .LevelW (LEVEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready = ~fifo_full;

`ifdef UART_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Two-flop synchroniser; resets to "not clear" so nothing starts before it settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok = ~cts_sync_q;
`else
  assign cts_ok = 1'b1;
`endif

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 pin_q, pin_d;
  logic                 bit_done, can_start;

  assign bit_done    = (baud_cnt_q == CntW'(BaudDiv - 1));
  assign can_start   = ~fifo_empty & cts_ok;
  assign uart_tx_pin = pin_q;
  assign tx_busy     = (state_q != StIdle);

  // Frame sequencing; the pin is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = '0;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    pin_d      = pin_q;
    fifo_pop   = 1'b0;

    if (state_q != StIdle && !bit_done) baud_cnt_d = baud_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        pin_d = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_idx_d = '0;
          pin_d     = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_idx_q == BitW'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              pin_d   = par_bit_q;
            end else begin
              state_d    = StStop;
              stop_idx_d = 1'b0;
              pin_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            pin_d     = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
          pin_d      = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Start a frame from idle, or chain straight out of the last stop bit.
    if ((state_q == StIdle || (state_q == StStop && bit_done && state_d == StIdle)) && can_start)
    begin
      fifo_pop   = 1'b1;
      state_d    = StStart;
      baud_cnt_d = '0;
      shift_d    = fifo_rdata;
      par_bit_d  = (^fifo_rdata) ^ (parity_odd ? ParityOdd : ParityEven);
      par_en_d   = parity_en;
      two_stop_d = two_stop;
      pin_d      = 1'b0;
    end
  end

  // FSM and frame registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      pin_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      pin_q      <= pin_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg at default parameters (divisor 234).
module tb_uart_tx_cfg;

  localparam int unsigned Div = 234;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en, parity_odd, two_stop;
  logic       uart_tx_pin;
  logic       tx_busy;
  logic [4:0] fifo_level;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg u_dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .two_stop    (two_stop),
`ifdef UART_TX_CTS_EN
    .cts_n       (cts_n),
`endif
    .uart_tx_pin (uart_tx_pin),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Push one word into an idle block; returns at the first cycle of its start bit.
  task automatic push_one(input string tag, input logic [7:0] data);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    check_eq({tag, " latency pin"}, uart_tx_pin, 1'b1);
    check_eq({tag, " level"}, fifo_level, 5'd1);
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Called on some cycle of the start bit (first_c); follows the frame bit by bit and
  // ends on the first cycle after it, expecting either idle or a chained start bit.
  task automatic expect_frame(input string tag, input logic [7:0] data, input bit pe,
                              input bit pb, input bit ts, input bit chain, input int first_c);
    logic [11:0] bits;
    int          nb;
    int          c0;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    nb = 9;
    if (pe) begin
      bits[nb] = pb;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (ts) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      c0 = (b == 0) ? first_c : 0;
      for (int c = c0; c < int'(Div); c++) begin
        if (!(b == 0 && c == c0)) @(negedge clk);
        if (c == 0 || c == int'(Div) - 1)
          check_eq($sformatf("%s bit%0d c%0d", tag, b, c), uart_tx_pin, bits[b]);
        if (c == 0) check_eq($sformatf("%s busy bit%0d", tag, b), tx_busy, 1'b1);
      end
    end
    @(negedge clk);
    if (chain) begin
      check_eq({tag, " chained start"}, uart_tx_pin, 1'b0);
      check_eq({tag, " chained busy"}, tx_busy, 1'b1);
    end else begin
      check_eq({tag, " end pin"}, uart_tx_pin, 1'b1);
      check_eq({tag, " end busy"}, tx_busy, 1'b0);
    end
  endtask

  initial begin
    int n_acc;
    int n;
    int bad;
    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst pin", uart_tx_pin, 1'b1);
    check_eq("rst busy", tx_busy, 1'b0);
    check_eq("rst level", fifo_level, 5'd0);
    check_eq("rst ready", tx_ready, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1 then idle after 10 bit times.
    push_one("x55", 8'h55);
    expect_frame("x55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // 0x07 even parity, two stop bits: parity bit 1, 12 bit times.
    parity_en = 1'b1;
    two_stop  = 1'b1;
    push_one("x07e", 8'h07);
    expect_frame("x07e", 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    parity_odd = 1'b1;
    push_one("x07o", 8'h07);
    expect_frame("x07o", 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    repeat (3) @(negedge clk);

    // Config change after the frame has started only affects the next frame.
    tx_data  = 8'h3c;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hc7;
    @(negedge clk);
    tx_valid  = 1'b0;
    parity_en = 1'b1;
    expect_frame("cfg f1", 8'h3c, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    expect_frame("cfg f2", 8'hc7, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    parity_en = 1'b0;

    // Hold tx_valid for 18 cycles: 17 accepted, FIFO full.
    do_reset();
    n_acc    = 0;
    tx_data  = 8'h10;
    tx_valid = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      bad = int'(tx_ready);
      @(negedge clk);
      if (bad != 0) begin
        n_acc++;
        tx_data = 8'h10 + 8'(n_acc);
      end
    end
    check_eq("fill accepted", n_acc, 17);
    check_eq("fill ready", tx_ready, 1'b0);
    check_eq("fill level", fifo_level, 5'd16);
    n = 0;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("fill ready wait", n, 2324);
    check_eq("f2 start pin", uart_tx_pin, 1'b0);
    check_eq("f2 start busy", tx_busy, 1'b1);
    @(negedge clk);
    check_eq("18th level", fifo_level, 5'd16);
    check_eq("18th ready", tx_ready, 1'b0);
    tx_valid = 1'b0;
    expect_frame("b2b f2", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    check_eq("b2b f3 level", fifo_level, 5'd15);

    // Reset during DATA of frame 2 with 5 words still queued.
    do_reset();
    check_eq("rst2 level", fifo_level, 5'd0);
    check_eq("rst2 ready", tx_ready, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tx_data  = 8'ha0 + 8'(i);
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (2834) @(negedge clk);
    check_eq("pre-rst f2 pin", uart_tx_pin, 1'b0);
    check_eq("pre-rst level", fifo_level, 5'd5);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid rst pin", uart_tx_pin, 1'b1);
    check_eq("mid rst level", fifo_level, 5'd0);
    check_eq("mid rst busy", tx_busy, 1'b0);
    rst = 1'b0;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (uart_tx_pin !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check_eq("post rst quiet", bad, 0);

`ifdef UART_TX_CTS_EN
    // Flow control: held while cts_n high, start 3 edges after it drops.
    cts_n = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_data  = 8'h30 + 8'(i);
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("cts hold pin", uart_tx_pin, 1'b1);
    check_eq("cts hold busy", tx_busy, 1'b0);
    check_eq("cts hold level", fifo_level, 5'd3);
    cts_n = 1'b0;
    @(negedge clk);
    check_eq("cts +1 pin", uart_tx_pin, 1'b1);
    @(negedge clk);
    check_eq("cts +2 pin", uart_tx_pin, 1'b1);
    @(negedge clk);
    cts_n = 1'b1;
    expect_frame("cts f1", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (20) @(negedge clk);
    check_eq("cts held level", fifo_level, 5'd2);
    check_eq("cts held pin", uart_tx_pin, 1'b1);
    cts_n = 1'b0;
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
